// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are bursts ended by req_last, BURST_LEN accepts or a stall timeout; read snooping tracks occupancy.
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int DEPTH_WIDTH = 8,
    parameter int STALL_MAX   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    input  logic                            fifo_wr_vld,
    input  logic                            fifo_rd_en,
    input  logic                            fifo_rd_vld,
    output logic                            grant_active,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [DEPTH_WIDTH:0]            level,
    output logic                            overflow_err,
    output logic                            underflow_err
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int BEAT_W  = $clog2(BURST_LEN + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam int LVL_W   = DEPTH_WIDTH + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic                gnt_valid;
    logic                gnt_last;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                wr_acc;
    logic                rd_acc;

    // First requester after rr_ptr, wrapping, so the last winner is searched last.
    always_comb begin : arb_pick
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    assign gnt_valid = req_valid[grant_id_q];
    assign gnt_last  = req_last[grant_id_q];
    assign gnt_data  = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state_q == S_BURST) begin
            fifo_wr_en            = gnt_valid;
            fifo_wr_data          = gnt_data;
            req_ready[grant_id_q] = gnt_valid & fifo_wr_vld;
        end
    end

    assign wr_acc = fifo_wr_en & fifo_wr_vld;
    assign rd_acc = fifo_rd_en & fifo_rd_vld;

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d     = S_BURST;
                    grant_id_d  = pick_id;
                    rr_ptr_d    = pick_id;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (wr_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A back-pressured cycle is not the producer's fault, so it never counts as a stall.
                if (gnt_valid) begin
                    stall_cnt_d = '0;
                end else if (fifo_wr_vld) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                if ((wr_acc && (gnt_last || beat_cnt_d == BEAT_W'(BURST_LEN))) ||
                    stall_cnt_d == STALL_W'(STALL_MAX)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc && level_q == LVL_FULL) begin
            overflow_d = 1'b1;
        end
        if (rd_acc && level_q == '0) begin
            underflow_d = 1'b1;
        end
        if (wr_acc && !rd_acc && level_q != LVL_FULL) begin
            level_d = level_q + 1'b1;
        end else if (rd_acc && !wr_acc && level_q != '0) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign grant_active  = (state_q == S_BURST);
    assign grant_id      = grant_id_q;
    assign level         = level_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule
